// File: rtl/cpu_mem_unit_pkg.sv
// Shared encodings for the CPU memory-access stage: address/data source selects
// and the bus handshake state machine states.
package cpu_mem_unit_pkg;

    localparam logic [1:0] READ_FROM_PC  = 2'd0;
    localparam logic [1:0] READ_FROM_A   = 2'd1;
    localparam logic [1:0] READ_FROM_ALU = 2'd2;

    localparam logic WRITE_FROM_ALU = 1'b0;
    localparam logic WRITE_FROM_RES = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_mem_unit.sv
// Memory access stage: muxes bus address/write data, runs a ready handshake with
// wait states and timeout, and owns the opcode and memValue registers.
module cpu_mem_unit
    import cpu_mem_unit_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  memAddr,
    input  logic        we,
    input  logic        writeDataSource,
    input  logic        saveOpcode,
    input  logic        saveMem,
    input  logic [15:0] pc,
    input  logic [15:0] regA,
    input  logic [15:0] aluOut,
    input  logic [15:0] resultReg,
    output logic [15:0] busAddr,
    output logic [15:0] busWData,
    output logic        busRe,
    output logic        busWe,
    input  logic [15:0] busRData,
    input  logic        busReady,
    output logic [15:0] opcode,
    output logic [15:0] memValue,
    output logic        stall,
    output logic        busError
);

    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [15:0]      r_hold_addr, r_hold_wdata;
    logic             r_hold_we, r_hold_save_op, r_hold_save_mem;
    logic [15:0]      r_opcode, r_mem_value;
    logic             r_bus_error;

    logic             w_req;
    logic [15:0]      w_sel_addr, w_sel_wdata;
    logic             w_bus_re, w_bus_we, w_stall;
    logic             w_cap_op, w_cap_mem, w_hold_load, w_enter_err;

    assign w_req = we | saveOpcode | saveMem;

    always_comb begin
        case (memAddr)
            READ_FROM_A:   w_sel_addr = regA;
            READ_FROM_ALU: w_sel_addr = aluOut;
            default:       w_sel_addr = pc;
        endcase
        w_sel_wdata = (writeDataSource == WRITE_FROM_RES) ? resultReg : aluOut;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        busAddr      = w_sel_addr;
        busWData     = w_sel_wdata;
        w_bus_re     = 1'b0;
        w_bus_we     = 1'b0;
        w_stall      = 1'b0;
        w_cap_op     = 1'b0;
        w_cap_mem    = 1'b0;
        w_hold_load  = 1'b0;
        w_enter_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_bus_re = w_req & ~we;
                w_bus_we = we;
                if (w_req) begin
                    if (busReady) begin
                        w_cap_op  = saveOpcode & ~we;
                        w_cap_mem = saveMem & ~we;
                    end else begin
                        w_stall      = 1'b1;
                        w_hold_load  = 1'b1;
                        w_cnt_next   = L_ONE;
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Bus is frozen on the held request; live CPU inputs are ignored.
                busAddr  = r_hold_addr;
                busWData = r_hold_wdata;
                w_bus_re = ~r_hold_we;
                w_bus_we = r_hold_we;
                if (busReady) begin
                    w_cap_op     = r_hold_save_op;
                    w_cap_mem    = r_hold_save_mem;
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == L_TIMEOUT) begin
                    w_stall      = 1'b1;
                    w_enter_err  = 1'b1;
                    w_state_next = ST_ERROR;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + L_ONE;
                end
            end
            default: begin
                busAddr  = r_hold_addr;
                busWData = r_hold_wdata;
                w_stall  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_hold_addr     <= '0;
            r_hold_wdata    <= '0;
            r_hold_we       <= 1'b0;
            r_hold_save_op  <= 1'b0;
            r_hold_save_mem <= 1'b0;
            r_opcode        <= '0;
            r_mem_value     <= '0;
            r_bus_error     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_hold_load) begin
                // Read flags are dropped when a write is requested alongside them.
                r_hold_addr     <= w_sel_addr;
                r_hold_wdata    <= w_sel_wdata;
                r_hold_we       <= we;
                r_hold_save_op  <= saveOpcode & ~we;
                r_hold_save_mem <= saveMem & ~we;
            end
            if (w_cap_op) begin
                r_opcode <= busRData;
            end
            if (w_cap_mem) begin
                r_mem_value <= busRData;
            end
            if (w_enter_err) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    assign busRe    = w_bus_re & ~rst;
    assign busWe    = w_bus_we & ~rst;
    assign stall    = w_stall & ~rst;
    assign opcode   = r_opcode;
    assign memValue = r_mem_value;
    assign busError = r_bus_error;

endmodule

// File: doc/cpu_mem_unit.md
Name: cpu_mem_unit

Overview:
- Memory access stage directly downstream of the CPU control unit. Consumes its memory-side controls: memAddr select, we, writeDataSource, saveOpcode, saveMem.
- Forms the bus address and write data, and runs a ready-handshake to external memory with wait states and a timeout.
- Owns the instruction register (opcode) and the internal value register (memValue).
- Asserts stall to freeze the CPU while an access is pending.

Parameters:
- TIMEOUT, 15, maximum WAIT cycles without busReady before a bus error
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- memAddr  in  2  address source select: READ_FROM_PC=0, READ_FROM_A=1, READ_FROM_ALU=2; 3 reserved, treated as PC
- we  in  1  write request
- writeDataSource  in  1  write data select: WRITE_FROM_ALU=0, WRITE_FROM_RES=1
- saveOpcode  in  1  read request, captured into opcode
- saveMem  in  1  read request, captured into memValue
- pc  in  16  program counter
- regA  in  16  A register
- aluOut  in  16  ALU result
- resultReg  in  16  internal result register
- busAddr  out  16  memory address
- busWData  out  16  memory write data
- busRe  out  1  read strobe
- busWe  out  1  write strobe
- busRData  in  16  memory read data, valid when busReady=1
- busReady  in  1  access completes this cycle
- opcode  out  16  instruction register
- memValue  out  16  internal value register
- stall  out  1  CPU holds state and suppresses all register enables this cycle
- busError  out  1  sticky timeout flag

Behaviour:
- Request (req) = we | saveOpcode | saveMem.
- Priority: when we is set, the access is a write and any read flags raised in the same cycle are ignored.
- State machine: IDLE, WAIT, ERROR.
- IDLE:
  - Bus outputs are combinational from the inputs.
  - busAddr = pc, regA or aluOut per memAddr.
  - busWData = aluOut or resultReg per writeDataSource.
  - busRe = req & ~we; busWe = we.
  - req & busReady (zero-wait access): stall=0; a read captures busRData into opcode (saveOpcode) or memValue (saveMem) at the clock edge. Both flags set captures both registers. Stay in IDLE.
  - req & ~busReady: stall=1. Latch addr, wdata, kind and capture flags into hold registers. Counter=1. Go to WAIT.
  - No req: busRe=busWe=0, stall=0.
- WAIT:
  - Bus driven from the hold registers; CPU inputs are ignored.
  - busReady=1: stall=0, capture per the held flags, go to IDLE.
  - Else, counter==TIMEOUT: go to ERROR.
  - Else: counter++, stall=1.
- ERROR:
  - busRe=busWe=0, stall=1, busError=1.
  - Remains in ERROR until rst, so the CPU is halted.
- Latency: a zero-wait access completes in the request cycle. With N wait cycles, stall is high for N cycles and the access completes in cycle N+1. busReady in WAIT cycle k (k ≤ TIMEOUT) completes normally.
- The bus holds address, data and strobe stable for the whole access.
- Reset:
  - State=IDLE, opcode=0, memValue=0, busError=0, counter=0, hold registers=0.
  - busRe, busWe and stall are forced to 0 during any cycle with rst=1.
  - rst in WAIT aborts the access with no capture; IDLE is entered on the next cycle.
- busReady outside an access is ignored.

Decomposition:
- Shared constants file: READ_FROM_* and WRITE_FROM_* encodings, state encodings.
- No sub-module; the address/data multiplexer stays inline.

Test Plan:
- Zero-wait fetch: memAddr=PC, pc=16'h0010, saveOpcode=1, busReady=1, busRData=16'h1234 -> busAddr=16'h0010, busRe=1, stall=0 that cycle; opcode=16'h1234 next cycle.
- Two-wait read: memAddr=ALU, aluOut=16'h0200, saveMem=1, busReady low 2 cycles, then high with 16'hBEEF -> stall high 2 cycles; busAddr stable at 16'h0200; memValue=16'hBEEF; stall=0 in cycle 3.
- Write from RES: we=1, writeDataSource=RES, resultReg=16'h00AA, memAddr=A, regA=16'h0300, one wait cycle -> busWe=1 for 2 cycles with busAddr=16'h0300 and busWData=16'h00AA; opcode and memValue unchanged.
- Timeout: TIMEOUT=15, read with busReady held 0 -> ERROR after the 15th WAIT cycle; busError=1; stall stays 1; busRe=0; cleared only by rst.
- Reset in WAIT: rst in the 2nd wait cycle with busReady=1 in that same cycle -> no capture; busRe=0 that cycle; IDLE next cycle; all registers 0.
- Write priority: we=1 and saveMem=1 together -> busWe=1, busRe=0, memValue unchanged.
